// File: rtl/memory_stage_pkg.sv
// Shared definitions for the memory-stage LSU: access-size codes, FSM states,
// and the byte-lane helpers used by both the store and load paths.
package memory_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  // Size comes from funct3[1:0] alone; 2'b10 and 2'b11 both mean word.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lane[0];
      default: return lane != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_enable(input logic [2:0] f3, input logic [1:0] lane);
    case (f3[1:0])
      SZ_BYTE: return 4'b0001 << lane;
      SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] data);
    case (f3[1:0])
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   return {{24{b[7]}}, b};
      F3_LBU:  return {24'b0, b};
      F3_LH:   return {{16{h[15]}}, h};
      F3_LHU:  return {16'b0, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/memory_stage_lsu_if.sv
// Execute/hazard-side bundle into the memory stage and its registered outputs.
interface memory_stage_lsu_if;
  logic        i_StallM;
  logic        i_FlushM;
  logic        i_ValidE;
  logic        i_MemReadE;
  logic        i_MemWriteE;
  logic [2:0]  i_Funct3E;
  logic [31:0] i_ALUResultE;
  logic [31:0] i_WriteDataE;
  logic [31:0] i_PCPlus4E;
  logic [4:0]  i_RdE;
  logic [4:0]  o_RdM;
  logic [31:0] o_ALUResultM;
  logic [31:0] o_PCPlus4M;
  logic [31:0] o_ReadDataM;
  logic        o_ValidM;
  logic        o_MemBusyM;
  logic        o_MisalignM;

  modport master (
    output i_StallM, i_FlushM, i_ValidE, i_MemReadE, i_MemWriteE, i_Funct3E,
           i_ALUResultE, i_WriteDataE, i_PCPlus4E, i_RdE,
    input  o_RdM, o_ALUResultM, o_PCPlus4M, o_ReadDataM, o_ValidM, o_MemBusyM, o_MisalignM
  );

  modport slave (
    input  i_StallM, i_FlushM, i_ValidE, i_MemReadE, i_MemWriteE, i_Funct3E,
           i_ALUResultE, i_WriteDataE, i_PCPlus4E, i_RdE,
    output o_RdM, o_ALUResultM, o_PCPlus4M, o_ReadDataM, o_ValidM, o_MemBusyM, o_MisalignM
  );
endinterface

// File: rtl/lsu_byte_memory.sv
// Word-organised data memory with per-byte write enables and asynchronous read.
// Contents are deliberately not reset.
module lsu_byte_memory #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/memory_stage_lsu.sv
// RV32 memory stage: E->M pipeline register plus a load/store unit whose access
// latency is a parameter; latencies above one cycle stall the pipeline via o_MemBusyM.
module memory_stage_lsu
  import memory_stage_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int MEM_LATENCY = 1
) (
  input logic               i_Clk,
  input logic               i_Reset,
  memory_stage_lsu_if.slave bus
);

  localparam int         IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAST  = 3'(MEM_LATENCY - 1);

  logic        valid_m, read_m, write_m;
  logic [2:0]  funct3_m;
  logic [31:0] alu_m, wdata_m, pc4_m;
  logic [4:0]  rd_m;

  lsu_state_e  state, state_next;
  logic [2:0]  count, count_next;
  logic        busy, complete, mem_we;
  logic        advance, aligned_e, load_m, misalign_m;
  logic [31:0] mem_rdata;

  assign advance   = !bus.i_StallM && !busy;
  assign aligned_e = bus.i_ValidE && (bus.i_MemReadE || bus.i_MemWriteE) &&
                     !is_misaligned(bus.i_Funct3E, bus.i_ALUResultE[1:0]);

  // E->M register: reset/flush insert a bubble, stall or busy hold it
  always_ff @(posedge i_Clk) begin
    if (!i_Reset || bus.i_FlushM) begin
      valid_m  <= 1'b0;
      read_m   <= 1'b0;
      write_m  <= 1'b0;
      funct3_m <= '0;
      alu_m    <= '0;
      wdata_m  <= '0;
      pc4_m    <= '0;
      rd_m     <= '0;
    end else if (advance) begin
      valid_m  <= bus.i_ValidE;
      read_m   <= bus.i_MemReadE;
      write_m  <= bus.i_MemWriteE;
      funct3_m <= bus.i_Funct3E;
      alu_m    <= bus.i_ALUResultE;
      wdata_m  <= bus.i_WriteDataE;
      pc4_m    <= bus.i_PCPlus4E;
      rd_m     <= bus.i_RdE;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    if (bus.i_FlushM) begin
      state_next = ST_IDLE;
      count_next = '0;
    end else if (busy) begin
      count_next = count + 3'd1;
    end else if (advance) begin
      state_next = aligned_e ? ST_ACCESS : ST_IDLE;
      count_next = '0;
    end else if (complete) begin
      state_next = ST_DONE;
    end
  end

  // The store commits only on the completion edge, never from DONE
  always_comb begin
    busy     = (state == ST_ACCESS) && (count != LAST);
    complete = (state == ST_ACCESS) && (count == LAST);
    mem_we   = complete && write_m && i_Reset && !bus.i_FlushM;
  end

  lsu_byte_memory #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_mem (
    .clk  (i_Clk),
    .we   (mem_we),
    .be   (byte_enable(funct3_m, alu_m[1:0])),
    .idx  (alu_m[IDX_W+1:2]),
    .wdata(store_data(funct3_m, wdata_m)),
    .rdata(mem_rdata)
  );

  assign load_m     = valid_m && read_m && !write_m;
  assign misalign_m = is_misaligned(funct3_m, alu_m[1:0]);

  assign bus.o_RdM        = rd_m;
  assign bus.o_ALUResultM = alu_m;
  assign bus.o_PCPlus4M   = pc4_m;
  assign bus.o_MemBusyM   = busy;
  assign bus.o_ValidM     = valid_m && !busy;
  assign bus.o_MisalignM  = valid_m && (read_m || write_m) && misalign_m;
  assign bus.o_ReadDataM  = (load_m && !misalign_m && !busy) ?
                            load_extend(funct3_m, alu_m[1:0], mem_rdata) : '0;

endmodule

// File: tb/tb_memory_stage_lsu.sv
// Directed bench for memory_stage_lsu: three instances cover latency 1, latency 3
// and a 16-word memory; expected values are hand-computed constants.
module tb_memory_stage_lsu;
  import memory_stage_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall, flush, read_e, write_e;
  logic [2:0]  funct3_e;
  logic [31:0] alu_e, wdata_e, pc4_e;
  logic [4:0]  rd_e;
  logic        valid1, valid3, valid16;
  int          total = 0;
  int          bad   = 0;

  memory_stage_lsu_if if1 ();
  memory_stage_lsu_if if3 ();
  memory_stage_lsu_if if16 ();

  assign {if1.i_StallM, if1.i_FlushM, if1.i_ValidE, if1.i_MemReadE, if1.i_MemWriteE, if1.i_Funct3E,
          if1.i_ALUResultE, if1.i_WriteDataE, if1.i_PCPlus4E, if1.i_RdE} =
         {stall, flush, valid1, read_e, write_e, funct3_e, alu_e, wdata_e, pc4_e, rd_e};
  assign {if3.i_StallM, if3.i_FlushM, if3.i_ValidE, if3.i_MemReadE, if3.i_MemWriteE, if3.i_Funct3E,
          if3.i_ALUResultE, if3.i_WriteDataE, if3.i_PCPlus4E, if3.i_RdE} =
         {stall, flush, valid3, read_e, write_e, funct3_e, alu_e, wdata_e, pc4_e, rd_e};
  assign {if16.i_StallM, if16.i_FlushM, if16.i_ValidE, if16.i_MemReadE, if16.i_MemWriteE, if16.i_Funct3E,
          if16.i_ALUResultE, if16.i_WriteDataE, if16.i_PCPlus4E, if16.i_RdE} =
         {stall, flush, valid16, read_e, write_e, funct3_e, alu_e, wdata_e, pc4_e, rd_e};

  memory_stage_lsu #(.DEPTH_WORDS(1024), .MEM_LATENCY(1)) dut1  (.i_Clk(clk), .i_Reset(rst_n), .bus(if1));
  memory_stage_lsu #(.DEPTH_WORDS(1024), .MEM_LATENCY(3)) dut3  (.i_Clk(clk), .i_Reset(rst_n), .bus(if3));
  memory_stage_lsu #(.DEPTH_WORDS(16),   .MEM_LATENCY(1)) dut16 (.i_Clk(clk), .i_Reset(rst_n), .bus(if16));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_e();
    valid1  = 1'b0;
    valid3  = 1'b0;
    valid16 = 1'b0;
    read_e  = 1'b0;
    write_e = 1'b0;
  endtask

  task automatic set_op(input int sel, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data);
    read_e   = ld;
    write_e  = st;
    funct3_e = f3;
    alu_e    = addr;
    wdata_e  = data;
    pc4_e    = addr + 32'h1000;
    rd_e     = addr[4:0] ^ 5'd3;
    valid1   = (sel == 1);
    valid3   = (sel == 3);
    valid16  = (sel == 16);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    funct3_e = '0; alu_e = '0; wdata_e = '0; pc4_e = '0; rd_e = '0;
    idle_e();
    cyc(); cyc();
    chk("rst_valid1", 32'(if1.o_ValidM), 32'd0);
    chk("rst_busy3", 32'(if3.o_MemBusyM), 32'd0);
    chk("rst_alu1", if1.o_ALUResultM, 32'd0);
    chk("rst_rdata3", if3.o_ReadDataM, 32'd0);
    rst_n = 1'b1;

    // latency 1: store then back-to-back extended loads
    set_op(1, 1'b0, 1'b1, F3_LW, 32'h10, 32'hDEADBEEF); cyc();
    chk("sw_valid", 32'(if1.o_ValidM), 32'd1);
    chk("sw_busy", 32'(if1.o_MemBusyM), 32'd0);
    chk("sw_rdata", if1.o_ReadDataM, 32'd0);
    set_op(1, 1'b1, 1'b0, F3_LB, 32'h13, 32'd0); cyc();
    chk("lb", if1.o_ReadDataM, 32'hFFFFFFDE);
    set_op(1, 1'b1, 1'b0, F3_LBU, 32'h13, 32'd0); cyc();
    chk("lbu", if1.o_ReadDataM, 32'h000000DE);
    set_op(1, 1'b1, 1'b0, F3_LH, 32'h12, 32'd0); cyc();
    chk("lh", if1.o_ReadDataM, 32'hFFFFDEAD);
    chk("lh_rd", 32'(if1.o_RdM), 32'h11);
    chk("lh_alu", if1.o_ALUResultM, 32'h12);
    chk("lh_pc4", if1.o_PCPlus4M, 32'h1012);
    set_op(1, 1'b1, 1'b0, F3_LHU, 32'h10, 32'd0); cyc();
    chk("lhu", if1.o_ReadDataM, 32'h0000BEEF);

    set_op(1, 1'b0, 1'b1, F3_LW, 32'h20, 32'd0); cyc();
    set_op(1, 1'b0, 1'b1, F3_LB, 32'h21, 32'h0000007F); cyc();
    set_op(1, 1'b1, 1'b0, F3_LW, 32'h20, 32'd0); cyc();
    chk("sb_lw", if1.o_ReadDataM, 32'h00007F00);
    set_op(1, 1'b0, 1'b1, F3_LH, 32'h22, 32'h1234BEEF); cyc();
    set_op(1, 1'b1, 1'b0, F3_LW, 32'h20, 32'd0); cyc();
    chk("sh_lw", if1.o_ReadDataM, 32'hBEEF7F00);

    // misaligned accesses touch nothing
    set_op(1, 1'b1, 1'b0, F3_LH, 32'h11, 32'd0); cyc();
    chk("mis_lh_flag", 32'(if1.o_MisalignM), 32'd1);
    chk("mis_lh_rdata", if1.o_ReadDataM, 32'd0);
    chk("mis_lh_busy", 32'(if1.o_MemBusyM), 32'd0);
    set_op(1, 1'b1, 1'b0, F3_LW, 32'h22, 32'd0); cyc();
    chk("mis_lw_flag", 32'(if1.o_MisalignM), 32'd1);
    chk("mis_lw_rdata", if1.o_ReadDataM, 32'd0);
    set_op(1, 1'b0, 1'b1, F3_LW, 32'h22, 32'hFFFFFFFF); cyc();
    chk("mis_sw_flag", 32'(if1.o_MisalignM), 32'd1);
    set_op(1, 1'b1, 1'b0, F3_LW, 32'h20, 32'd0); cyc();
    chk("mis_mem_same", if1.o_ReadDataM, 32'hBEEF7F00);
    chk("aligned_flag", 32'(if1.o_MisalignM), 32'd0);

    // stall holds a completed load
    set_op(1, 1'b1, 1'b0, F3_LW, 32'h10, 32'd0); cyc();
    stall = 1'b1; idle_e(); cyc();
    chk("stall_rdata", if1.o_ReadDataM, 32'hDEADBEEF);
    chk("stall_valid", 32'(if1.o_ValidM), 32'd1);
    stall = 1'b0; cyc();
    chk("bubble_valid", 32'(if1.o_ValidM), 32'd0);

    // latency 3
    set_op(3, 1'b0, 1'b1, F3_LW, 32'h40, 32'h11111111); cyc(); idle_e(); cyc(); cyc(); cyc();
    set_op(3, 1'b0, 1'b1, F3_LW, 32'h10, 32'hCAFEF00D); cyc(); idle_e(); cyc(); cyc(); cyc();
    set_op(3, 1'b1, 1'b0, F3_LW, 32'h10, 32'd0); cyc();
    chk("l3_c0_busy", 32'(if3.o_MemBusyM), 32'd1);
    chk("l3_c0_valid", 32'(if3.o_ValidM), 32'd0);
    idle_e(); cyc();
    chk("l3_c1_busy", 32'(if3.o_MemBusyM), 32'd1);
    chk("l3_c1_valid", 32'(if3.o_ValidM), 32'd0);
    cyc();
    chk("l3_c2_busy", 32'(if3.o_MemBusyM), 32'd0);
    chk("l3_c2_valid", 32'(if3.o_ValidM), 32'd1);
    chk("l3_c2_rdata", if3.o_ReadDataM, 32'hCAFEF00D);
    cyc();
    chk("l3_after_valid", 32'(if3.o_ValidM), 32'd0);

    // flush aborts a pending store
    set_op(3, 1'b0, 1'b1, F3_LW, 32'h40, 32'h12345678); cyc();
    chk("fl_c0_busy", 32'(if3.o_MemBusyM), 32'd1);
    idle_e(); cyc();
    chk("fl_c1_busy", 32'(if3.o_MemBusyM), 32'd1);
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("fl_busy_drop", 32'(if3.o_MemBusyM), 32'd0);
    chk("fl_valid", 32'(if3.o_ValidM), 32'd0);
    set_op(3, 1'b1, 1'b0, F3_LW, 32'h40, 32'd0); cyc(); idle_e(); cyc(); cyc();
    chk("fl_old_value", if3.o_ReadDataM, 32'h11111111);
    cyc();

    // 16-word memory: address wraps, then a one-cycle reset
    set_op(16, 1'b0, 1'b1, F3_LW, 32'h44, 32'hA5A5A5A5); cyc();
    set_op(16, 1'b1, 1'b0, F3_LW, 32'h04, 32'd0); cyc();
    chk("wrap_rdata", if16.o_ReadDataM, 32'hA5A5A5A5);
    chk("wrap_valid", 32'(if16.o_ValidM), 32'd1);
    idle_e(); rst_n = 1'b0; cyc(); rst_n = 1'b1;
    chk("rst16_ctl", {24'd0, if16.o_ValidM, if16.o_MemBusyM, if16.o_MisalignM, if16.o_RdM}, 32'd0);
    chk("rst16_rdata", if16.o_ReadDataM, 32'd0);
    chk("rst16_alu", if16.o_ALUResultM, 32'd0);
    chk("rst16_pc4", if16.o_PCPlus4M, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
